// File: rtl/z80_bus_sync.sv
// Z80 bus front end: synchronises and glitch-filters the strobes and emits one
// qualified event per bus cycle. The optional abort timer is enabled by Z80_BUS_TIMEOUT_EN.
module z80_bus_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  input  logic        z80_wr,
  input  logic        z80_rd,
  input  logic        z80_iorq,
  input  logic        z80_mreq,
  input  logic        z80_m1,
  output logic        cyc_valid,
  output logic [2:0]  cyc_type,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_wdata,
  output logic        cyc_end,
  output logic        busy,
  output logic        timeout
);

  // state  | meaning
  // ARM    | wait until the synced bus has been seen idle long enough to trust it
  // IDLE   | no cycle in progress; look for a non-zero raw type
  // QUAL   | raw type seen once; confirm it on the next clk
  // ACTIVE | event issued; wait for MREQ and IORQ to both release
  typedef enum logic [1:0] {ARM, IDLE, QUAL, ACTIVE} state_t;

  localparam int ARM_W = $clog2(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("z80_bus_sync: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [4:0]  strb_sync [SYNC_STAGES];
  logic [15:0] a_sync    [SYNC_STAGES];
  logic [7:0]  d_sync    [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        strb_sync[i] <= '1;
        a_sync[i]    <= '1;
        d_sync[i]    <= '1;
      end
    end else begin
      strb_sync[0] <= {z80_m1, z80_mreq, z80_iorq, z80_rd, z80_wr};
      a_sync[0]    <= z80_a;
      d_sync[0]    <= z80_d_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        strb_sync[i] <= strb_sync[i-1];
        a_sync[i]    <= a_sync[i-1];
        d_sync[i]    <= d_sync[i-1];
      end
    end
  end

  logic m1_l, mreq_l, iorq_l, rd_l, wr_l;
  logic bus_idle;
  logic [2:0] raw_type;

  assign {m1_l, mreq_l, iorq_l, rd_l, wr_l} = ~strb_sync[SYNC_STAGES-1];
  assign bus_idle = !mreq_l && !iorq_l;

  always_comb begin
    raw_type = 3'd0;
    if (mreq_l && !iorq_l) begin
      if (rd_l && !wr_l)      raw_type = m1_l ? 3'd1 : 3'd2;
      else if (wr_l && !rd_l) raw_type = 3'd3;
    end else if (iorq_l && !mreq_l) begin
      if (m1_l)               raw_type = (!rd_l && !wr_l) ? 3'd6 : 3'd0;
      else if (rd_l && !wr_l) raw_type = 3'd4;
      else if (wr_l && !rd_l) raw_type = 3'd5;
    end
  end

  state_t           state;
  logic [2:0]       qual_type;
  logic [ARM_W-1:0] arm_cnt;

`ifdef Z80_BUS_TIMEOUT_EN
  localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (TO_BITS < 8) ? 8 : ((TO_BITS > 16) ? 16 : TO_BITS);
  logic [TW-1:0] to_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARM;
      qual_type <= 3'd0;
      arm_cnt   <= ARM_W'(SYNC_STAGES);
      cyc_valid <= 1'b0;
      cyc_type  <= 3'd0;
      cyc_addr  <= 16'd0;
      cyc_wdata <= 8'd0;
      cyc_end   <= 1'b0;
      busy      <= 1'b0;
`ifdef Z80_BUS_TIMEOUT_EN
      to_cnt    <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      cyc_valid <= 1'b0;
      cyc_end   <= 1'b0;
      case (state)
        // The sync chain is preset high, so idle must persist until it has
        // been refilled from the pins before the bus is trusted.
        ARM: begin
          busy <= 1'b0;
          if (bus_idle) begin
            if (arm_cnt == '0) state <= IDLE;
            else               arm_cnt <= arm_cnt - 1'b1;
          end else begin
            arm_cnt <= ARM_W'(SYNC_STAGES);
          end
        end
        IDLE: begin
          busy <= 1'b0;
          if (raw_type != 3'd0) begin
            qual_type <= raw_type;
            state     <= QUAL;
          end
        end
        QUAL: begin
          if (raw_type == qual_type) begin
            cyc_valid <= 1'b1;
            busy      <= 1'b1;
            cyc_type  <= raw_type;
            cyc_addr  <= a_sync[SYNC_STAGES-1];
            cyc_wdata <= (raw_type == 3'd3 || raw_type == 3'd5) ? d_sync[SYNC_STAGES-1] : 8'd0;
`ifdef Z80_BUS_TIMEOUT_EN
            to_cnt    <= TW'(TIMEOUT_CYCLES - 1);
`endif
            state     <= ACTIVE;
          end else begin
            state <= IDLE;
          end
        end
        ACTIVE: begin
          if (bus_idle) begin
            cyc_end <= 1'b1;
            state   <= IDLE;
          end
`ifdef Z80_BUS_TIMEOUT_EN
          else if (to_cnt == '0) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            arm_cnt <= ARM_W'(SYNC_STAGES);
            state   <= ARM;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
`endif
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule
